// File: rtl/program_memory_loadable_if.sv
// Fetch and program-load signals of program_memory_loadable, grouped as one bus.
// parity_err exists only when PMEM_PARITY_EN is defined.
interface program_memory_loadable_if #(
    parameter int INS_W  = 6,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] addr;
    logic              rd_en;
    logic [INS_W-1:0]  ins_out;
    logic              ins_valid;
    logic              load_start;
    logic [INS_W-1:0]  load_data;
    // Load handshake: a word transfers on every rising edge where load_valid and
    // load_ready are both 1; load_last is only meaningful on such a beat, and the
    // source may change load_data freely while load_valid is low.
    logic              load_valid;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic              busy;
`ifdef PMEM_PARITY_EN
    logic              parity_err;
`endif

    modport master (
        output addr, rd_en, load_start, load_data, load_valid, load_last,
        input  ins_out, ins_valid, load_ready, load_done, busy
`ifdef PMEM_PARITY_EN
        , input parity_err
`endif
    );

    modport slave (
        input  addr, rd_en, load_start, load_data, load_valid, load_last,
        output ins_out, ins_valid, load_ready, load_done, busy
`ifdef PMEM_PARITY_EN
        , output parity_err
`endif
    );
endinterface

// File: rtl/program_memory_loadable.sv
// Run-time loadable instruction memory: self-clears to FILL_WORD after reset, then
// serves 1-cycle registered fetches. Optional even parity per word: PMEM_PARITY_EN.
module program_memory_loadable #(
    parameter int               INS_W     = 6,
    parameter int               ADDR_W    = 5,
    parameter int               DEPTH     = 32,
    parameter logic [INS_W-1:0] FILL_WORD = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    program_memory_loadable_if.slave bus,
    output logic [1:0]            dbg_state  // CLEAR=0, IDLE=1, LOAD=2, DONE=3
);
`ifdef PMEM_PARITY_EN
    localparam int MEM_W = INS_W + 1;
`else
    localparam int MEM_W = INS_W;
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_LOAD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [INS_W-1:0]  ins_out_q, ins_out_d;
    logic              ins_valid_q, ins_valid_d;
    logic              load_ready_q, load_ready_d;
    logic              load_done_q, load_done_d;
    logic              busy_q, busy_d;
    logic              parity_err_q, parity_err_d;

    logic [MEM_W-1:0]  mem_q [DEPTH];
    logic              mem_we;
    logic [INS_W-1:0]  wr_word;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  rd_word;
    logic              in_range;

`ifdef PMEM_PARITY_EN
    assign mem_wdata = {^wr_word, wr_word};
`else
    assign mem_wdata = wr_word;
`endif
    assign in_range = (bus.addr <= LAST_ADDR);
    assign rd_word  = mem_q[bus.addr];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        ins_out_d    = ins_out_q;
        ins_valid_d  = 1'b0;
        load_ready_d = load_ready_q;
        load_done_d  = 1'b0;
        busy_d       = busy_q;
        parity_err_d = 1'b0;
        mem_we       = 1'b0;
        wr_word      = FILL_WORD;
        case (state_q)
            S_CLEAR: begin
                mem_we = 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            S_IDLE: begin
                // A load request pre-empts a fetch issued in the same cycle.
                if (bus.load_start) begin
                    state_d      = S_LOAD;
                    ptr_d        = '0;
                    load_ready_d = 1'b1;
                    busy_d       = 1'b1;
                end else if (bus.rd_en) begin
                    ins_valid_d  = 1'b1;
                    ins_out_d    = in_range ? rd_word[INS_W-1:0] : FILL_WORD;
                    parity_err_d = in_range && (^rd_word);
                end
            end
            S_LOAD: begin
                if (bus.load_valid && load_ready_q) begin
                    mem_we  = 1'b1;
                    wr_word = bus.load_data;
                    if (bus.load_last || ptr_q == LAST_ADDR) begin
                        state_d      = S_DONE;
                        load_ready_d = 1'b0;
                        load_done_d  = 1'b1;
                        busy_d       = 1'b0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_CLEAR;
                ptr_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            ptr_q        <= '0;
            ins_out_q    <= '0;
            ins_valid_q  <= 1'b0;
            load_ready_q <= 1'b0;
            load_done_q  <= 1'b0;
            busy_q       <= 1'b1;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ins_out_q    <= ins_out_d;
            ins_valid_q  <= ins_valid_d;
            load_ready_q <= load_ready_d;
            load_done_q  <= load_done_d;
            busy_q       <= busy_d;
            parity_err_q <= parity_err_d;
        end
    end

    // Storage has no reset; the CLEAR sweep initialises it instead.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[ptr_q] <= mem_wdata;
        end
    end

    assign bus.ins_out    = ins_out_q;
    assign bus.ins_valid  = ins_valid_q;
    assign bus.load_ready = load_ready_q;
    assign bus.load_done  = load_done_q;
    assign bus.busy       = busy_q;
    assign dbg_state      = state_q;
`ifdef PMEM_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    logic unused_parity;
    assign unused_parity = parity_err_q;
`endif
endmodule
